dac_cfg_serializer: RTL

DAC_CFG_SERIALIZER -- requirements
Module: dac_cfg_serializer

---
 rtl/dac_cfg_pkg.sv | 13 +
 rtl/dac_cfg_serializer_piso_frame.sv | 28 ++
 rtl/dac_cfg_serializer.sv | 101 ++++++++++
 3 files changed

// File: rtl/dac_cfg_pkg.sv
// Shared types and default widths for the DAC configuration serializer.
package dac_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int VREF_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/dac_cfg_serializer_piso_frame.sv
// One serial channel: loads {word, marker} and shifts it out marker first, zero-filling behind.
module piso_frame #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift_en,
    input  logic [W-1:0] word,
    output logic         sd
);

    logic [W:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (load) begin
            sr <= {word, 1'b1};
        end else if (shift_en) begin
            sr <= {1'b0, sr[W:1]};
        end
    end

    // The line is the register LSB itself, so it is 0 whenever the register has drained.
    assign sd = sr[0];

endmodule

// File: rtl/dac_cfg_serializer.sv
// Serializes a reference word and a data word onto two marker-framed lines.
//
// state | meaning
// IDLE  | lines 0, waiting for start with a non-zero channel enable
// SHIFT | frames on the wire, busy high, bit_cnt = current bit (1-based)
// DONE  | one-cycle done pulse, lines 0, start ignored
module dac_cfg_serializer
    import dac_cfg_pkg::*;
#(
    parameter int VREF_W = VREF_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        ch_en,
    input  logic [VREF_W-1:0] vref_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              sd_vref,
    output logic              sd_data,
    output logic              busy,
    output logic              done
);

    localparam logic [3:0] VREF_LEN = 4'(VREF_W + 1);
    localparam logic [3:0] DATA_LEN = 4'(DATA_W + 1);
    localparam logic [3:0] BOTH_LEN = (VREF_LEN > DATA_LEN) ? VREF_LEN : DATA_LEN;

    state_t     state;
    logic [3:0] bit_cnt;
    logic [3:0] frame_len;
    logic       accept;
    logic       shift_en;

    assign accept   = (state == IDLE) && start && (ch_en != 2'b00);
    assign shift_en = (state == SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            frame_len <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= SHIFT;
                        busy    <= 1'b1;
                        bit_cnt <= 4'd1;
                        case (ch_en)
                            2'b01:   frame_len <= VREF_LEN;
                            2'b10:   frame_len <= DATA_LEN;
                            default: frame_len <= BOTH_LEN;
                        endcase
                    end
                end
                SHIFT: begin
                    // Counter holds at the frame end value rather than wrapping.
                    if (bit_cnt == frame_len) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    done    <= 1'b0;
                    bit_cnt <= '0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    piso_frame #(.W(VREF_W)) u_vref (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept && ch_en[0]),
        .shift_en (shift_en),
        .word     (vref_in),
        .sd       (sd_vref)
    );

    piso_frame #(.W(DATA_W)) u_data (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept && ch_en[1]),
        .shift_en (shift_en),
        .word     (data_in),
        .sd       (sd_data)
    );

endmodule
